result_ctrl: RTL

RESULT_CTRL -- requirements
Module: result_ctrl

---
 rtl/result_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/result_ctrl.sv
// Result controller: waits LATENCY cycles after start, captures the nine PE results, then streams them out with valid/ready.
// Optional macro RESULT_CHECKSUM_EN appends a tenth word holding the sum of the nine results.
module result_ctrl #(
  parameter int DATA_W  = 18,
  parameter int LATENCY = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9*DATA_W-1:0]   c_flat,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int N_RES = 9;
`ifdef RESULT_CHECKSUM_EN
  localparam int N_WORDS = N_RES + 1;
`else
  localparam int N_WORDS = N_RES;
`endif
  localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   buf_q [N_RES];
  logic [DATA_W-1:0]   buf_d [N_RES];
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [3:0]          idx_inc;
  logic [DATA_W-1:0]   next_word;

  assign idx_inc = idx_q + 4'd1;

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  // Sum of the captured buffer, wrapping at DATA_W bits.
  always_comb begin
    checksum = '0;
    for (int k = 0; k < N_RES; k++) begin
      checksum = checksum + buf_q[k];
    end
  end

  assign next_word = (idx_inc == 4'd9) ? checksum : buf_q[idx_inc];
`else
  assign next_word = buf_q[idx_inc];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : CAPTURE;
        end
      end
      // Leave one cycle early so the capture lands exactly LATENCY cycles after start.
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        for (int k = 0; k < N_RES; k++) begin
          buf_d[k] = c_flat[k*DATA_W +: DATA_W];
        end
        idx_d       = 4'd0;
        out_data_d  = c_flat[0 +: DATA_W];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d      = idx_inc;
            out_data_d = next_word;
            out_last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < N_RES; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      buf_q       <= buf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
